// File: rtl/magic_ctrl_if.sv
// cpu_bus: CPU-side bus bundle seen by the magic-mode controller.
//   a       16-bit address (memory address, or I/O port with the config
//           register index in a[15:8])
//   d       8-bit write data from the CPU
//   rd, wr  read / write strobes
//   memreq  memory request
//   ioreq   I/O request
//   m1      opcode fetch cycle
// The master modport is the CPU (or bench) side; the slave modport is the
// controller side, which only observes the bus.
interface cpu_bus;
  logic [15:0] a;
  logic [7:0]  d;
  logic        rd;
  logic        wr;
  logic        memreq;
  logic        ioreq;
  logic        m1;

  modport master (output a, d, rd, wr, memreq, ioreq, m1);
  modport slave  (input  a, d, rd, wr, memreq, ioreq, m1);
endinterface

// File: rtl/magic_ctrl.sv
// magic_ctrl: magic-mode / NMI service controller.
//
// Latches trigger sources on an INT edge and raises NMI. It maps the
// service ROM from the NMI entry fetch onwards and leaves magic mode (or
// chains back in) on reads of the exit/chain addresses. A stuck NMI is
// abandoned after NMI_TIMEOUT cycles. While the ROM is mapped, an I/O
// config space on port CFG_PORT exposes the cause/status register (index 0,
// write-1-to-clear) and NREG-1 plain config bytes.
//
// Ports:
//   clk28         system clock
//   rst_n         asynchronous active-low reset
//   bus           CPU bus (slave modport of cpu_bus)
//   trig          NSRC level trigger requests
//   n_int         current INT level
//   n_int_next    next INT level (INT edge = n_int high, n_int_next low)
//   n_nmi         NMI to CPU, active-low, registered
//   magic_mode    magic mode active
//   magic_map     service ROM mapped (includes same-cycle early arm)
//   cause         latched trigger causes
//   cfg           config image, byte i = register i (byte 0 = status)
//   d_out         registered config read data
//   d_out_active  d_out drives the data bus
module magic_ctrl #(
  parameter int              NSRC        = 2,
  parameter int              NREG        = 16,
  parameter logic [NREG*8-1:0] CFG_INIT  = '0,
  parameter logic [15:0]     ENTRY_ADDR  = 16'h0066,
  parameter logic [15:0]     EXIT_ADDR   = 16'hF000,
  parameter logic [15:0]     CHAIN_ADDR  = 16'hF008,
  parameter logic [7:0]      CFG_PORT    = 8'hFF,
  parameter int              NMI_TIMEOUT = 1024,
  parameter bit              ON_START    = 1'b1
) (
  input  logic              clk28,
  input  logic              rst_n,
  cpu_bus.slave             bus,
  input  logic [NSRC-1:0]   trig,
  input  logic              n_int,
  input  logic              n_int_next,
  output logic              n_nmi,
  output logic              magic_mode,
  output logic              magic_map,
  output logic [NSRC-1:0]   cause,
  output logic [NREG*8-1:0] cfg,
  output logic [7:0]        d_out,
  output logic              d_out_active
);

  localparam int          IW       = (NREG > 2) ? $clog2(NREG) : 1;
  localparam logic [8:0]  NREG9    = 9'(NREG);
  localparam logic [15:0] TMO_LAST = 16'(NMI_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    NMI_PEND,
    MAPPED,
    UNMAP,
    CHAIN_WAIT
  } state_t;

  state_t          state;
  logic            map0;
  logic            chain;
  logic            timeout_flag;
  logic [15:0]     timer;
  logic [NSRC-1:0] cause_next;
  logic [7:0]      cfg_regs [1:NREG-1];

  logic            int_edge;
  logic            any_trig;
  logic            entry_fetch;
  logic            early_arm;
  logic            cfg_cs;
  logic            cfg_wr;
  logic            cfg_rd;
  logic [7:0]      idx;
  logic [IW-1:0]   reg_idx;
  logic            idx_ok;
  logic            reg0_wr;
  logic [7:0]      status;
  logic [7:0]      rd_val;

  assign int_edge    = n_int && !n_int_next;
  assign any_trig    = |trig;
  assign entry_fetch = bus.m1 && bus.memreq && (bus.a == ENTRY_ADDR);

  // Early arm lets the ROM answer the very fetch that enters (or re-enters)
  // magic mode, before map0 has had a chance to register.
  assign early_arm = (state == NMI_PEND && entry_fetch) ||
                     (state == CHAIN_WAIT && bus.m1 && bus.memreq);
  assign magic_map = map0 || early_arm;

  assign cfg_cs  = magic_map && bus.ioreq && (bus.a[7:0] == CFG_PORT);
  assign cfg_wr  = cfg_cs && bus.wr;
  assign cfg_rd  = cfg_cs && bus.rd;
  assign idx     = bus.a[15:8];
  assign reg_idx = idx[IW-1:0];
  assign idx_ok  = ({1'b0, idx} < NREG9);
  assign reg0_wr = cfg_wr && (idx == 8'h00);

  // Status register: timeout in bit 7, magic mode in bit 6, causes at the bottom.
  always_comb begin
    status         = '0;
    status[7]      = timeout_flag;
    status[6]      = magic_mode;
    status[NSRC-1:0] = cause;
  end

  // Write-1-to-clear is applied first so a trigger arriving on the same
  // cycle as a clear is never lost.
  always_comb begin
    cause_next = cause;
    if (reg0_wr)
      cause_next = cause_next & ~bus.d[NSRC-1:0];
    if (int_edge && any_trig)
      cause_next = cause_next | trig;
  end

  // Main controller FSM with all control outputs registered.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ON_START ? MAPPED : IDLE;
      magic_mode   <= ON_START;
      map0         <= ON_START;
      n_nmi        <= 1'b1;
      cause        <= '0;
      timeout_flag <= 1'b0;
      timer        <= '0;
      chain        <= 1'b0;
    end else begin
      cause <= cause_next;
      if (reg0_wr && bus.d[7])
        timeout_flag <= 1'b0;

      unique case (state)
        IDLE: begin
          if (int_edge && any_trig) begin
            n_nmi      <= 1'b0;
            magic_mode <= 1'b1;
            timer      <= '0;
            state      <= NMI_PEND;
          end
        end

        NMI_PEND: begin
          if (timer != 16'hFFFF)
            timer <= timer + 16'd1;
          // The entry fetch takes priority over a coincident timeout.
          if (entry_fetch) begin
            n_nmi <= 1'b1;
            map0  <= 1'b1;
            state <= MAPPED;
          end else if (timer == TMO_LAST) begin
            n_nmi        <= 1'b1;
            magic_mode   <= 1'b0;
            timeout_flag <= 1'b1;
            state        <= IDLE;
          end
        end

        MAPPED: begin
          if (bus.memreq && bus.rd && bus.a == EXIT_ADDR) begin
            magic_mode <= 1'b0;
            chain      <= 1'b0;
            state      <= UNMAP;
          end else if (bus.memreq && bus.rd && bus.a == CHAIN_ADDR) begin
            chain <= 1'b1;
            state <= UNMAP;
          end
        end

        // Keep the ROM mapped until the exit/chain read cycle has finished.
        UNMAP: begin
          if (!bus.memreq) begin
            map0  <= 1'b0;
            state <= chain ? CHAIN_WAIT : IDLE;
          end
        end

        CHAIN_WAIT: begin
          if (bus.m1 && bus.memreq) begin
            map0  <= 1'b1;
            state <= MAPPED;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Plain config bytes 1..NREG-1; byte 0 is the status register above.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++)
        cfg_regs[i] <= CFG_INIT[i*8 +: 8];
    end else if (cfg_wr && idx_ok && reg_idx != '0) begin
      cfg_regs[reg_idx] <= bus.d;
    end
  end

  always_comb begin
    cfg      = '0;
    cfg[7:0] = status;
    for (int i = 1; i < NREG; i++)
      cfg[i*8 +: 8] = cfg_regs[i];
  end

  // Indices beyond the register file read as an open bus.
  always_comb begin
    rd_val = 8'hFF;
    if (idx_ok)
      rd_val = (reg_idx == '0) ? status : cfg_regs[reg_idx];
  end

  // Registered read port: data and drive enable follow cfg_rd by one cycle.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      d_out        <= 8'h00;
      d_out_active <= 1'b0;
    end else begin
      d_out_active <= cfg_rd;
      d_out        <= cfg_rd ? rd_val : 8'h00;
    end
  end

endmodule

// File: tb/tb_magic_ctrl.sv
// tb_magic_ctrl: directed self-checking bench for magic_ctrl with default
// parameters except a non-zero reset image for config byte 3 (8'h5A).
module tb_magic_ctrl;

  localparam int NSRC = 2;
  localparam int NREG = 16;
  localparam logic [NREG*8-1:0] INIT = 128'h5A << 24;

  logic              clk28;
  logic              rst_n;
  logic [NSRC-1:0]   trig;
  logic              n_int;
  logic              n_int_next;
  logic              n_nmi;
  logic              magic_mode;
  logic              magic_map;
  logic [NSRC-1:0]   cause;
  logic [NREG*8-1:0] cfg;
  logic [7:0]        d_out;
  logic              d_out_active;

  int checks;
  int failures;

  cpu_bus bus_if ();

  magic_ctrl #(
    .NSRC     (NSRC),
    .NREG     (NREG),
    .CFG_INIT (INIT)
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .trig         (trig),
    .n_int        (n_int),
    .n_int_next   (n_int_next),
    .n_nmi        (n_nmi),
    .magic_mode   (magic_mode),
    .magic_map    (magic_map),
    .cause        (cause),
    .cfg          (cfg),
    .d_out        (d_out),
    .d_out_active (d_out_active)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Drive one bus cycle's worth of inputs.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic rd, input logic wr,
                               input logic memreq, input logic ioreq,
                               input logic m1);
    bus_if.a      = a;
    bus_if.d      = d;
    bus_if.rd     = rd;
    bus_if.wr     = wr;
    bus_if.memreq = memreq;
    bus_if.ioreq  = ioreq;
    bus_if.m1     = m1;
  endtask

  task automatic busIdle();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    trig       = '0;
    n_int      = 1'b1;
    n_int_next = 1'b1;
    busIdle();

    tick();
    tick();
    checkOutput("rst_n_nmi", 16'(n_nmi), 16'h1);
    checkOutput("rst_mode", 16'(magic_mode), 16'h1);
    checkOutput("rst_map", 16'(magic_map), 16'h1);
    checkOutput("rst_cause", 16'(cause), 16'h0);
    checkOutput("rst_dact", 16'(d_out_active), 16'h0);
    checkOutput("rst_cfg3", 16'(cfg[31:24]), 16'h5A);
    checkOutput("rst_cfg5", 16'(cfg[47:40]), 16'h00);
    rst_n = 1'b1;

    // Leave magic mode through the exit address.
    $display("[TB] exit from start-up magic mode");
    applyStimulus(16'hF000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("exit_mode", 16'(magic_mode), 16'h0);
    checkOutput("exit_map_held", 16'(magic_map), 16'h1);
    busIdle();
    tick();
    checkOutput("exit_map_drop", 16'(magic_map), 16'h0);

    // NMI entry: trigger 1 on an INT edge, then the entry fetch.
    $display("[TB] NMI entry");
    trig = 2'b10;
    n_int_next = 1'b0;
    tick();
    checkOutput("nmi_low", 16'(n_nmi), 16'h0);
    checkOutput("nmi_cause", 16'(cause), 16'h2);
    checkOutput("nmi_mode", 16'(magic_mode), 16'h1);
    checkOutput("nmi_map_off", 16'(magic_map), 16'h0);
    trig = '0;
    n_int_next = 1'b1;
    applyStimulus(16'h0066, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("entry_early_arm", 16'(magic_map), 16'h1);
    tick();
    busIdle();
    #1;
    checkOutput("entry_nmi_high", 16'(n_nmi), 16'h1);
    checkOutput("entry_map", 16'(magic_map), 16'h1);

    // Config write then readback.
    $display("[TB] config access");
    applyStimulus(16'h05FF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("cfg5_write", 16'(cfg[47:40]), 16'hA5);
    applyStimulus(16'h05FF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("rd_not_yet", 16'(d_out_active), 16'h0);
    tick();
    checkOutput("rd5_active", 16'(d_out_active), 16'h1);
    checkOutput("rd5_data", 16'(d_out), 16'hA5);
    applyStimulus(16'h20FF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rd_oob", 16'(d_out), 16'hFF);
    applyStimulus(16'h03FF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rd3_init", 16'(d_out), 16'h5A);
    applyStimulus(16'h00FF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rd0_status", 16'(d_out), 16'h42);
    busIdle();
    tick();
    checkOutput("rd_drop", 16'(d_out_active), 16'h0);

    // Trigger while mapped: cause only, no new NMI; then clear bit 0.
    $display("[TB] cause set and clear");
    trig = 2'b01;
    n_int_next = 1'b0;
    tick();
    checkOutput("mapped_trig_cause", 16'(cause), 16'h3);
    checkOutput("mapped_trig_nmi", 16'(n_nmi), 16'h1);
    trig = '0;
    n_int_next = 1'b1;
    applyStimulus(16'h00FF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("w1c_cause", 16'(cause), 16'h2);
    busIdle();

    // Chain: unmap for a gap, re-arm on the next M1.
    $display("[TB] chain");
    applyStimulus(16'hF008, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("chain_mode", 16'(magic_mode), 16'h1);
    busIdle();
    tick();
    checkOutput("chain_gap_map", 16'(magic_map), 16'h0);
    checkOutput("chain_gap_mode", 16'(magic_mode), 16'h1);
    applyStimulus(16'h1234, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("chain_early_arm", 16'(magic_map), 16'h1);
    tick();
    busIdle();
    #1;
    checkOutput("chain_remap", 16'(magic_map), 16'h1);
    checkOutput("chain_mode_end", 16'(magic_mode), 16'h1);

    // Leave, then let an NMI time out.
    $display("[TB] NMI timeout");
    applyStimulus(16'hF000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    busIdle();
    tick();
    trig = 2'b10;
    n_int_next = 1'b0;
    tick();
    trig = '0;
    n_int_next = 1'b1;
    checkOutput("tmo_start", 16'(n_nmi), 16'h0);
    repeat (1023) tick();
    checkOutput("tmo_still_low", 16'(n_nmi), 16'h0);
    tick();
    checkOutput("tmo_nmi_high", 16'(n_nmi), 16'h1);
    checkOutput("tmo_mode", 16'(magic_mode), 16'h0);
    checkOutput("tmo_status", 16'(cfg[7:0]), 16'h82);

    // Asynchronous reset while NMI is pending.
    $display("[TB] reset in NMI_PEND");
    trig = 2'b01;
    n_int_next = 1'b0;
    tick();
    trig = '0;
    n_int_next = 1'b1;
    checkOutput("pend_nmi_low", 16'(n_nmi), 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_nmi", 16'(n_nmi), 16'h1);
    checkOutput("arst_cause", 16'(cause), 16'h0);
    checkOutput("arst_status", 16'(cfg[7:0]), 16'h40);
    checkOutput("arst_cfg5", 16'(cfg[47:40]), 16'h00);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
